// File: rtl/spi_shift_engine_pkg.sv
// Shared constants for the SPI shift engine. The IDLE code is also decoded by the
// baud-rate divider, so it must stay 4'hA.
package spi_shift_engine_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'hA,
        ST_SETUP = 4'h1,
        ST_SHIFT = 4'h2,
        ST_HOLD  = 4'h3,
        ST_DONE  = 4'h4
    } state_t;

endpackage

// File: rtl/spi_shift_engine_sclk_sync.sv
// Brings the divided SCLK into the system clock domain and turns its level steps into
// one-cycle leading/trailing pulses relative to CPOL.
module spi_sclk_sync (
    input  logic clock,
    input  logic reset,
    input  logic sclk_in,
    input  logic cpol,
    input  logic qual,
    output logic sclk_sync,
    output logic lead_pulse,
    output logic trail_pulse
);

    logic r_s1, r_s2, r_s3;
    logic w_step;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sclk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // The synchronised level moves one step at a time, so at most one pulse fires.
    assign w_step      = qual && (r_s2 != r_s3);
    assign lead_pulse  = w_step && (r_s2 != cpol);
    assign trail_pulse = w_step && (r_s2 == cpol);
    assign sclk_sync   = r_s2;

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master transfer sequencer: chip-select timing, MOSI shifting and MISO capture,
// paced by the divided SCLK from the baud-rate divider.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [4:0]        word_len,
    input  logic              sclk_in,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              miso,
    output logic              mosi,
    output logic              cs_n,
    output logic              sclk_out,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [3:0]        state
);

    localparam int CNT_W = 8;

    state_t              r_state, w_next;
    logic                r_cs_n, r_mosi, r_rx_valid;
    logic                r_lsb, r_cpha;
    logic [4:0]          r_len;
    logic [CNT_W-1:0]    r_cnt;
    logic [5:0]          r_bit_cnt;
    logic [DATA_W-1:0]   r_tx, r_rx, r_rx_data;

    logic                w_sclk_sync, w_lead, w_trail;
    logic                w_tx_ready, w_accept, w_last;
    logic                w_setup_exit, w_hold_exit, w_sample, w_shift_out, w_tx_head;
    logic [5:0]          w_len_p1, w_cnt_at_trail, w_acc_shamt, w_out_shamt;
    logic [DATA_W-1:0]   w_rx_out;

    spi_sclk_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .sclk_in     (sclk_in),
        .cpol        (cpol),
        .qual        (r_state == ST_SHIFT),
        .sclk_sync   (w_sclk_sync),
        .lead_pulse  (w_lead),
        .trail_pulse (w_trail)
    );

    assign w_tx_ready = enable && (r_state == ST_IDLE) && !reset;
    assign w_len_p1   = {1'b0, r_len} + 6'd1;
    // With CPHA=1 the trailing edge itself carries the last sample.
    assign w_cnt_at_trail = r_cpha ? (r_bit_cnt + 6'd1) : r_bit_cnt;
    assign w_last         = (w_cnt_at_trail == w_len_p1);

    assign w_setup_exit = (r_state == ST_SETUP) && (r_cnt == '0);
    assign w_hold_exit  = (r_state == ST_HOLD) && (r_cnt == '0) && enable;
    assign w_sample     = (w_lead && !r_cpha) || (w_trail && r_cpha);
    assign w_shift_out  = (w_setup_exit && !r_cpha) || (w_lead && r_cpha)
                        || (w_trail && !r_cpha && !w_last);
    assign w_tx_head    = r_lsb ? r_tx[0] : r_tx[DATA_W-1];

    // MSB-first words are left-aligned on load; LSB-first captures land at the top.
    assign w_acc_shamt = 6'(DATA_W - 1) - {1'b0, word_len};
    assign w_out_shamt = 6'(DATA_W - 1) - {1'b0, r_len};
    assign w_rx_out    = (r_lsb ? (r_rx >> w_out_shamt) : r_rx)
                       & ({DATA_W{1'b1}} >> w_out_shamt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid && w_tx_ready) begin
                    w_accept = 1'b1;
                    w_next   = ST_SETUP;
                end
            end
            ST_SETUP: if (r_cnt == '0) w_next = ST_SHIFT;
            ST_SHIFT: if (w_trail && w_last) w_next = ST_HOLD;
            ST_HOLD:  if (r_cnt == '0) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (!enable && (r_state != ST_IDLE)) w_next = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_len      <= '0;
            r_lsb      <= 1'b0;
            r_cpha     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_len     <= word_len;
                r_lsb     <= lsb_first;
                r_cpha    <= cpha;
                r_tx      <= lsb_first ? tx_data : (tx_data << w_acc_shamt);
                r_rx      <= '0;
                r_bit_cnt <= '0;
                r_cs_n    <= 1'b0;
                r_cnt     <= CNT_W'(CS_SETUP - 1);
            end
            if (w_sample) begin
                r_rx      <= r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_shift_out) begin
                r_mosi <= w_tx_head;
                r_tx   <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
            end
            if (((r_state == ST_SETUP) || (r_state == ST_HOLD)) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;
            if (w_trail && w_last)
                r_cnt <= CNT_W'(CS_HOLD - 1);
            if (w_hold_exit) begin
                r_cs_n     <= 1'b1;
                r_mosi     <= 1'b0;
                r_rx_data  <= w_rx_out;
                r_rx_valid <= 1'b1;
            end
            // Abort: drop the partial word and release the slave on the next clock.
            if (!enable && (r_state != ST_IDLE)) begin
                r_cs_n     <= 1'b1;
                r_mosi     <= 1'b0;
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = w_tx_ready;
    assign mosi     = r_mosi;
    assign cs_n     = r_cs_n;
    assign sclk_out = (r_state == ST_SHIFT) ? w_sclk_sync : cpol;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign state    = r_state;

endmodule
